// File: rtl/i2c_regfile_pkg.sv
// i2c_regfile_pkg: shared constants and types for the I2C register file, its slave and the port-A arbiter
package i2c_regfile_pkg;
  localparam int REGFILE_ADDR_W = 8;
  localparam int REGFILE_DATA_W = 8;
  localparam int EBR_RD_LAT = 2;
  localparam logic [6:0] I2C_SLAVE_ADDR = 7'h48;
  typedef enum logic {LOCK_OPEN, LOCK_HELD} lock_state_e;
  function automatic int onehot_idx(input logic [7:0] v);
    onehot_idx = 0;
    for (int i = 0; i < 8; i++) if (v[i]) onehot_idx = i;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin, searching from last+1 among masked requesters
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  input  logic [N-1:0]         mask,
  output logic [N-1:0]         gnt
);
  localparam int IW = $clog2(N);
  logic found;
  logic [IW-1:0] idx;
  always_comb begin
    gnt = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last) + k) % N);
      if (!found && req[idx] && mask[idx]) begin
        gnt[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: round-robin sharing of EBR port A with an optional
// ownership lock and tagged return of read data to the issuing requester
module regfile_port_arbiter
  import i2c_regfile_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = REGFILE_ADDR_W,
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int RD_LAT = EBR_RD_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ-1:0]    req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_din,
  output logic                  mem_wr,
  input  logic [DATA_W-1:0]     mem_dout
);
  localparam int IW = $clog2(NUM_REQ);
  lock_state_e state;
  logic [IW-1:0] last, owner, sel;
  logic [NUM_REQ-1:0] mask;
  logic accept;
  logic [RD_LAT-1:0] tag_v;
  logic [IW-1:0] tag_id [RD_LAT];
  assign mask = (state == LOCK_HELD) ? NUM_REQ'(1) << owner : '1;
  rr_arbiter #(.N(NUM_REQ)) u_rr (.req(req), .last(last), .mask(mask), .gnt(gnt));
  assign accept = |gnt;
  assign sel = IW'(onehot_idx(8'(gnt)));
  // EBR output is only meaningful while a tag emerges; zero otherwise
  assign rdata = |rvalid ? mem_dout : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOCK_OPEN;
      last <= IW'(NUM_REQ - 1);
      owner <= '0;
      mem_addr <= '0;
      mem_din <= '0;
      mem_wr <= 1'b0;
      tag_v <= '0;
      rvalid <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_id[i] <= '0;
    end else begin
      mem_wr <= accept && req_we[sel];
      if (accept) begin
        last <= sel;
        mem_addr <= req_addr[int'(sel)*ADDR_W +: ADDR_W];
        mem_din <= req_wdata[int'(sel)*DATA_W +: DATA_W];
      end
      if (state == LOCK_OPEN && accept && req_lock[sel]) begin
        state <= LOCK_HELD;
        owner <= sel;
      end else if (state == LOCK_HELD && !req_lock[owner]) state <= LOCK_OPEN;
      tag_v[0] <= accept && !req_we[sel];
      tag_id[0] <= sel;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      rvalid <= tag_v[RD_LAT-1] ? NUM_REQ'(1) << tag_id[RD_LAT-1] : '0;
    end
  end
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: directed tests of arbitration order, locking,
// read-data return, read-after-write and mid-flight reset
module tb_regfile_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req, req_we, req_lock, gnt, rvalid;
  logic [31:0] req_addr, req_wdata;
  logic [7:0] rdata, mem_addr, mem_din, mem_dout, q1;
  logic mem_wr;
  logic [7:0] ebr [256];
  int total = 0;
  int bad = 0;

  regfile_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din), .mem_wr(mem_wr),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // EBR stub: address sampled at one edge, data out after the next (2-edge latency)
  always @(posedge clk) begin
    if (mem_wr) ebr[mem_addr] <= mem_din;
    q1 <= ebr[mem_addr];
    mem_dout <= q1;
  end

  task automatic do_reset;
    req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic we, input logic lock, input logic [7:0] a, input logic [7:0] d);
    req[i] = 1'b1; req_we[i] = we; req_lock[i] = lock;
    req_addr[i*8 +: 8] = a; req_wdata[i*8 +: 8] = d;
  endtask

  task automatic test_reset;
    req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    rst_n = 1'b0;
    @(negedge clk);
    total++; if ({gnt, rvalid, rdata, mem_addr, mem_din, mem_wr} !== 29'd0) begin bad++; $display("FAIL reset_during gnt=%b rvalid=%b rdata=%h addr=%h din=%h wr=%b want all 0", gnt, rvalid, rdata, mem_addr, mem_din, mem_wr); end
    do_reset;
    @(negedge clk);
    total++; if ({gnt, rvalid, rdata, mem_addr, mem_din, mem_wr} !== 29'd0) begin bad++; $display("FAIL reset_after gnt=%b rvalid=%b rdata=%h addr=%h din=%h wr=%b want all 0", gnt, rvalid, rdata, mem_addr, mem_din, mem_wr); end
  endtask

  task automatic test_single_read;
    logic [3:0] exp_v;
    do_reset;
    ebr[8'h10] = 8'hA5;
    set_req(0, 1'b0, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b want=0001", gnt); end
    for (int t = 1; t <= 4; t++) begin
      @(posedge clk); #1 req = '0;
      @(negedge clk);
      exp_v = (t == 3) ? 4'b0001 : 4'b0000;
      total++; if (rvalid !== exp_v) begin bad++; $display("FAIL single_rvalid t=%0d got=%b want=%b", t, rvalid, exp_v); end
      total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL single_wr t=%0d got=%b want=0", t, mem_wr); end
      if (t == 1) begin
        total++; if (mem_addr !== 8'h10) begin bad++; $display("FAIL single_addr got=%h want=10", mem_addr); end
      end
      if (t == 3) begin
        total++; if (rdata !== 8'hA5) begin bad++; $display("FAIL single_rdata got=%h want=a5", rdata); end
      end
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g, exp_v;
    logic [7:0] exp_d, exp_a;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      ebr[8'h40 + i] = 8'hC0 + 8'(i);
      set_req(i, 1'b0, 1'b0, 8'h40 + 8'(i), 8'h00);
    end
    for (int t = 0; t < 10; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      if (t == 5) req = '0;
      @(negedge clk);
      exp_g = (t < 5) ? 4'b0001 << (t % 4) : 4'b0000;
      exp_v = (t >= 3 && t <= 7) ? 4'b0001 << ((t - 3) % 4) : 4'b0000;
      total++; if (gnt !== exp_g) begin bad++; $display("FAIL rr_gnt t=%0d got=%b want=%b", t, gnt, exp_g); end
      total++; if (rvalid !== exp_v) begin bad++; $display("FAIL rr_rvalid t=%0d got=%b want=%b", t, rvalid, exp_v); end
      if (exp_v != 4'b0000) begin
        exp_d = 8'hC0 + 8'((t - 3) % 4);
        total++; if (rdata !== exp_d) begin bad++; $display("FAIL rr_rdata t=%0d got=%h want=%h", t, rdata, exp_d); end
      end
      if (t >= 1 && t <= 5) begin
        exp_a = 8'h40 + 8'((t - 1) % 4);
        total++; if (mem_addr !== exp_a) begin bad++; $display("FAIL rr_addr t=%0d got=%h want=%h", t, mem_addr, exp_a); end
      end
    end
  endtask

  task automatic test_lock;
    logic [3:0] exp_g [7];
    exp_g = '{4'b0100, 4'b0000, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0000};
    do_reset;
    ebr[8'h20] = 8'h77;
    for (int t = 0; t < 7; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      req = '0;
      case (t)
        0: set_req(2, 1'b0, 1'b1, 8'h20, 8'h00);
        1: begin set_req(0, 1'b0, 1'b0, 8'h01, 8'h00); set_req(1, 1'b0, 1'b0, 8'h02, 8'h00); req_lock[2] = 1'b1; end
        2: begin set_req(0, 1'b0, 1'b0, 8'h01, 8'h00); set_req(1, 1'b0, 1'b0, 8'h02, 8'h00); set_req(2, 1'b1, 1'b0, 8'h20, 8'h5B); end
        3: begin set_req(0, 1'b0, 1'b0, 8'h01, 8'h00); set_req(1, 1'b0, 1'b0, 8'h02, 8'h00); set_req(3, 1'b0, 1'b0, 8'h23, 8'h00); end
        4: begin set_req(0, 1'b0, 1'b0, 8'h01, 8'h00); set_req(1, 1'b0, 1'b0, 8'h02, 8'h00); end
        5: set_req(1, 1'b0, 1'b0, 8'h02, 8'h00);
        default: req = '0;
      endcase
      @(negedge clk);
      total++; if (gnt !== exp_g[t]) begin bad++; $display("FAIL lock_gnt t=%0d got=%b want=%b", t, gnt, exp_g[t]); end
      total++; if (mem_wr !== (t == 3)) begin bad++; $display("FAIL lock_wr t=%0d got=%b want=%b", t, mem_wr, t == 3); end
      if (t == 1 || t == 3) begin
        total++; if (mem_addr !== 8'h20) begin bad++; $display("FAIL lock_addr t=%0d got=%h want=20", t, mem_addr); end
      end
      if (t == 3) begin
        total++; if (mem_din !== 8'h5B) begin bad++; $display("FAIL lock_din got=%h want=5b", mem_din); end
        total++; if (rvalid !== 4'b0100 || rdata !== 8'h77) begin bad++; $display("FAIL lock_read rvalid=%b rdata=%h want 0100/77", rvalid, rdata); end
      end
    end
  endtask

  task automatic test_read_after_write;
    logic [3:0] exp_v;
    do_reset;
    ebr[8'h30] = 8'h99;
    set_req(1, 1'b1, 1'b0, 8'h30, 8'h11);
    @(negedge clk);
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL raw_gnt_wr got=%b want=0010", gnt); end
    for (int t = 1; t < 7; t++) begin
      @(posedge clk); #1 req = '0;
      if (t == 1) set_req(0, 1'b0, 1'b0, 8'h30, 8'h00);
      @(negedge clk);
      if (t == 1) begin
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL raw_gnt_rd got=%b want=0001", gnt); end
        total++; if (mem_wr !== 1'b1 || mem_addr !== 8'h30 || mem_din !== 8'h11) begin bad++; $display("FAIL raw_write wr=%b addr=%h din=%h want 1/30/11", mem_wr, mem_addr, mem_din); end
      end
      exp_v = (t == 4) ? 4'b0001 : 4'b0000;
      total++; if (rvalid !== exp_v) begin bad++; $display("FAIL raw_rvalid t=%0d got=%b want=%b", t, rvalid, exp_v); end
      if (t == 4) begin
        total++; if (rdata !== 8'h11) begin bad++; $display("FAIL raw_rdata got=%h want=11", rdata); end
      end
    end
  endtask

  task automatic test_reset_midflight;
    do_reset;
    set_req(0, 1'b0, 1'b0, 8'h10, 8'h00);
    set_req(1, 1'b0, 1'b1, 8'h11, 8'h00);
    @(negedge clk);
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL mid_gnt0 got=%b want=0001", gnt); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL mid_gnt1 got=%b want=0010", gnt); end
    @(posedge clk); #1;
    req = '0; req_lock = '0;
    rst_n = 1'b0;
    @(negedge clk);
    total++; if ({gnt, rvalid, rdata, mem_addr, mem_din, mem_wr} !== 29'd0) begin bad++; $display("FAIL mid_reset_outs gnt=%b rvalid=%b rdata=%h addr=%h din=%h wr=%b want all 0", gnt, rvalid, rdata, mem_addr, mem_din, mem_wr); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if (rvalid !== 4'b0000 || rdata !== 8'h00) begin bad++; $display("FAIL mid_no_rvalid k=%0d rvalid=%b rdata=%h want 0000/00", k, rvalid, rdata); end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL mid_first_gnt got=%b want=0001", gnt); end
    @(posedge clk); #1 req = '0;
  endtask

  initial begin
    req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 256; i++) ebr[i] = 8'h00;
    test_reset;
    test_single_read;
    test_round_robin;
    test_lock;
    test_read_after_write;
    test_reset_midflight;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Shares the fabric-side port (port A) of the I2C register-file EBR among several on-chip requesters, while the I2C slave keeps exclusive use of port B. Round-robin arbitration issues at most one read or write per clock. Read data is routed back to the issuing requester after the fixed EBR latency. An optional lock lets one requester hold the port for atomic read-modify-write sequences.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 8, EBR address width
- DATA_W, 8, EBR data width
- RD_LAT, 2, clock edges from mem_addr presentation to valid mem_dout (1..4)

- clk  in  1  clock
- rst_n  in  1  reset: rst_n, asynchronous, active-low; clock clk
- req  in  NUM_REQ  access request per requester; held until granted
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_lock  in  NUM_REQ  keep ownership after this access
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- gnt  out  NUM_REQ  one-hot combinational grant; the access is accepted at the edge ending the cycle
- rvalid  out  NUM_REQ  one-hot, 1-cycle read-data strobe
- rdata  out  DATA_W  read data, qualified by rvalid
- mem_addr  out  ADDR_W  to EBR AddressA, registered
- mem_din  out  DATA_W  to EBR DataInA, registered
- mem_wr  out  1  to EBR WrA, registered 1-cycle pulse
- mem_dout  in  DATA_W  from EBR QA

## Operation
- Round-robin pointer `last` holds the index of the last granted requester.
- Search order is last+1, last+2, … modulo NUM_REQ. The first requester with req=1 gets gnt.
- `last` updates on each accepted access.
- Lock FSM states:
  - OPEN: normal round-robin.
  - LOCKED(owner).
- OPEN -> LOCKED: an access is accepted with req_lock[i]=1.
- In LOCKED, only the owner can be granted. Other requests wait.
- LOCKED -> OPEN: at the first edge where req_lock[owner]=0. Release does not need an access. An access accepted in that same cycle with lock=0 is allowed and releases the lock.
- An owner that idles while locked keeps the port indefinitely. This is legal; the integrator guarantees forward progress.
- On acceptance, mem_addr, mem_din and mem_wr are loaded from the granted requester.
- When no access is accepted: mem_wr=0, and mem_addr/mem_din hold their previous values.
- Reads push {valid, id} into a tag shift register of depth RD_LAT.
- When the tag emerges with valid=1: rvalid[id]=1 and rdata=mem_dout.
- Writes push valid=0, so no rvalid is produced.
- Port B collisions (same address, same cycle) are left to EBR write-through semantics. This block adds no coherence logic.

## Timing
- Reset values: gnt=0, rvalid=0, rdata=0, mem_wr=0, mem_addr=0, mem_din=0, last=NUM_REQ-1 (requester 0 wins first), lock state OPEN, tag pipe cleared.
- gnt depends combinationally on req, last and lock state. It has no dependency on req_addr or req_wdata.
- For an access accepted at edge E0:
  - mem_* are valid after E0.
  - The EBR samples them at E1.
- Read accepted at E0: rvalid is high in the cycle following edge E0+RD_LAT. With RD_LAT=2 this is the 3rd cycle after gnt.
- Throughput: one access per cycle. Back-to-back reads from different requesters return in issue order, one per cycle.
- Asynchronous reset mid-operation: in-flight reads are discarded and never produce rvalid. The lock is dropped.
- A requester deasserting req before grant is legal. No access is issued.

## Structure
- Shared package/include `i2c_regfile_pkg`:
  - REGFILE_ADDR_W=8, REGFILE_DATA_W=8, EBR_RD_LAT=2.
  - The I2C slave address constant.
  - The I2C slave also uses this package.
- Sub-module `rr_arbiter`: generic NUM_REQ round-robin, with inputs req, last and mask, and one-hot gnt out. It is purely combinational.
- The lock FSM, the issue registers and the tag pipe live in the top module.

## Test plan
- Reset, then req=4'b0001 read at addr 0x10 with EBR holding 0xA5 -> gnt[0] in cycle 0; mem_addr=0x10 next cycle; rvalid[0]=1 with rdata=0xA5 exactly 3 cycles after gnt; mem_wr stays 0.
- req=4'b1111 held, all reads -> grants in order 0,1,2,3,0; one mem access per cycle; rvalid order 0,1,2,3.
- Requester 2 reads 0x20 with lock=1, then writes 0x20 = 0x5B with lock=0, while req[0] and req[1] are held -> no other grants between the two accesses; mem_wr pulse with addr 0x20, din 0x5B; round-robin resumes at 3, then 0.
- Requester 1 write to 0x30 = 0x11 immediately followed by requester 0 read of 0x30 -> rvalid[0] with rdata=0x11; no rvalid for the write.
- rst_n pulsed low 1 cycle after two reads are issued -> no rvalid ever asserted; all outputs at reset values; the first grant afterwards goes to the lowest-index requester.
